// File: rtl/sysid_checker.sv
// -----------------------------------------------------------------------------
// sysid_checker
//
// Reads the system-ID slave twice: word 0 (system ID), then word 1 (build
// timestamp). Both words are captured and compared against the values this
// image was built with. The busy, done and match flags let boot and status
// logic hold off or flag a mismatched image.
//
// One check runs automatically after reset when AUTO_START=1. Every start
// request accepted in IDLE or DONE runs the check again.
//
// Ports
//   clock         in   1   system clock, rising edge
//   reset_n       in   1   asynchronous active-low reset
//   start         in   1   one-cycle check request, honoured only in IDLE/DONE
//   sid_address   out  1   word select to the slave (0 = ID, 1 = timestamp)
//   sid_read      out  1   read strobe to the slave
//   sid_readdata  in   32  slave read data
//   id_value      out  32  captured word 0
//   ts_value      out  32  captured word 1
//   busy          out  1   a check is in progress
//   done          out  1   the last check has completed (level)
//   id_match      out  1   id_value == EXPECTED_ID, valid while done=1
//   ts_match      out  1   ts_value == EXPECTED_TS, valid while done=1
// -----------------------------------------------------------------------------
module sysid_checker #(
  parameter logic [31:0] EXPECTED_ID  = 32'd0,
  parameter logic [31:0] EXPECTED_TS  = 32'd1395340222,
  parameter int unsigned READ_LATENCY = 0,
  parameter bit          AUTO_START   = 1'b1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        sid_address,
  output logic        sid_read,
  input  logic [31:0] sid_readdata,
  output logic [31:0] id_value,
  output logic [31:0] ts_value,
  output logic        busy,
  output logic        done,
  output logic        id_match,
  output logic        ts_match
);

  // Last wait-counter value of a read state. READ_LATENCY is limited to
  // 0..15, so the 4-bit counter reaches it without ever wrapping.
  localparam logic [3:0] LAST_WAIT = 4'(READ_LATENCY);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_ID,
    ST_RD_TS,
    ST_CMP,
    ST_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  wait_q, wait_d;
  logic        auto_q, auto_d;
  logic [31:0] id_value_q, id_value_d;
  logic [31:0] ts_value_q, ts_value_d;
  logic        id_match_q, id_match_d;
  logic        ts_match_q, ts_match_d;
  logic        done_q, done_d;
  logic        busy_q, busy_d;
  logic        sid_read_q, sid_read_d;
  logic        sid_address_q, sid_address_d;

  // Next-state logic. auto_q is set only by reset, so the first clock
  // after reset release behaves like an accepted start, and start on that
  // same edge cannot add a second run. The slave strobes and busy are
  // decoded from the next state and registered, so they change exactly at
  // state boundaries and do not glitch between the two words.
  always_comb begin
    state_d       = state_q;
    wait_d        = wait_q;
    auto_d        = 1'b0;
    id_value_d    = id_value_q;
    ts_value_d    = ts_value_q;
    id_match_d    = id_match_q;
    ts_match_d    = ts_match_q;
    done_d        = done_q;

    unique case (state_q)
      ST_IDLE: begin
        if (auto_q || start) begin
          state_d    = ST_RD_ID;
          wait_d     = 4'd0;
          done_d     = 1'b0;
          id_match_d = 1'b0;
          ts_match_d = 1'b0;
        end
      end
      ST_DONE: begin
        if (start) begin
          state_d    = ST_RD_ID;
          wait_d     = 4'd0;
          done_d     = 1'b0;
          id_match_d = 1'b0;
          ts_match_d = 1'b0;
        end
      end
      // Data is taken only on the last edge of the read window. Anything
      // the slave shows earlier is still settling and is ignored.
      ST_RD_ID: begin
        if (wait_q == LAST_WAIT) begin
          id_value_d = sid_readdata;
          state_d    = ST_RD_TS;
          wait_d     = 4'd0;
        end else begin
          wait_d = wait_q + 4'd1;
        end
      end
      ST_RD_TS: begin
        if (wait_q == LAST_WAIT) begin
          ts_value_d = sid_readdata;
          state_d    = ST_CMP;
          wait_d     = 4'd0;
        end else begin
          wait_d = wait_q + 4'd1;
        end
      end
      ST_CMP: begin
        id_match_d = (id_value_q == EXPECTED_ID);
        ts_match_d = (ts_value_q == EXPECTED_TS);
        done_d     = 1'b1;
        state_d    = ST_DONE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d        = (state_d == ST_RD_ID) || (state_d == ST_RD_TS) ||
                    (state_d == ST_CMP);
    sid_read_d    = (state_d == ST_RD_ID) || (state_d == ST_RD_TS);
    sid_address_d = (state_d == ST_RD_TS);
  end

  // State and output registers. An asynchronous reset aborts any check in
  // progress and clears every output immediately.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      wait_q        <= 4'd0;
      auto_q        <= AUTO_START;
      id_value_q    <= 32'd0;
      ts_value_q    <= 32'd0;
      id_match_q    <= 1'b0;
      ts_match_q    <= 1'b0;
      done_q        <= 1'b0;
      busy_q        <= 1'b0;
      sid_read_q    <= 1'b0;
      sid_address_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_q        <= wait_d;
      auto_q        <= auto_d;
      id_value_q    <= id_value_d;
      ts_value_q    <= ts_value_d;
      id_match_q    <= id_match_d;
      ts_match_q    <= ts_match_d;
      done_q        <= done_d;
      busy_q        <= busy_d;
      sid_read_q    <= sid_read_d;
      sid_address_q <= sid_address_d;
    end
  end

  assign sid_address = sid_address_q;
  assign sid_read    = sid_read_q;
  assign id_value    = id_value_q;
  assign ts_value    = ts_value_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign id_match    = id_match_q;
  assign ts_match    = ts_match_q;

endmodule

// File: tb/tb_sysid_checker.sv
// -----------------------------------------------------------------------------
// tb_sysid_checker
//
// Runs sysid_checker with a read latency of 2 and auto-start enabled.
// A timeline model tracks each check by counting clock edges since its
// accept edge. It derives the expected strobes, busy, done, captured words
// and match flags from that count. The bench plays the slave and shows the
// real word only in the cycle before the capture edge. Every other cycle
// carries random garbage, so a capture on the wrong edge is detected.
// -----------------------------------------------------------------------------
module tb_sysid_checker;

  localparam int          L       = 2;
  localparam logic [31:0] EXP_ID  = 32'd0;
  localparam logic [31:0] EXP_TS  = 32'h532B33BE;
  localparam int          LAST_ID = L;
  localparam int          LAST_TS = 2 * L + 1;
  localparam int          CMP_K   = 2 * L + 2;

  logic        clock = 1'b0;
  logic        reset_n = 1'b1;
  logic        start = 1'b0;
  logic        sid_address;
  logic        sid_read;
  logic [31:0] sid_readdata = 32'd0;
  logic [31:0] id_value;
  logic [31:0] ts_value;
  logic        busy;
  logic        done;
  logic        id_match;
  logic        ts_match;

  int testsRun = 0;
  int testsFailed = 0;

  // Timeline model state.
  bit          running;
  bit          autoPending;
  bit          expDone;
  bit          expIdMatch;
  bit          expTsMatch;
  int          k;
  logic [31:0] expId;
  logic [31:0] expTs;
  logic [31:0] word0;
  logic [31:0] word1;

  sysid_checker #(
    .EXPECTED_ID  (EXP_ID),
    .EXPECTED_TS  (EXP_TS),
    .READ_LATENCY (L),
    .AUTO_START   (1'b1)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .start        (start),
    .sid_address  (sid_address),
    .sid_read     (sid_read),
    .sid_readdata (sid_readdata),
    .id_value     (id_value),
    .ts_value     (ts_value),
    .busy         (busy),
    .done         (done),
    .id_match     (id_match),
    .ts_match     (ts_match)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t",
               tag, observed, expected, $time);
    end
  endtask

  task automatic modelReset();
    running     = 1'b0;
    autoPending = 1'b1;
    k           = 0;
    expDone     = 1'b0;
    expIdMatch  = 1'b0;
    expTsMatch  = 1'b0;
    expId       = 32'd0;
    expTs       = 32'd0;
  endtask

  // One rising edge with reset released. k is the index of the cycle that
  // this edge closes.
  task automatic modelEdge(input bit st);
    if (running) begin
      if (k == LAST_ID) expId = word0;
      if (k == LAST_TS) expTs = word1;
      if (k == CMP_K) begin
        running    = 1'b0;
        expDone    = 1'b1;
        expIdMatch = (expId == EXP_ID);
        expTsMatch = (expTs == EXP_TS);
      end else begin
        k++;
      end
    end else if (autoPending || st) begin
      running    = 1'b1;
      k          = 0;
      expDone    = 1'b0;
      expIdMatch = 1'b0;
      expTsMatch = 1'b0;
    end
    autoPending = 1'b0;
  endtask

  task automatic checkAll();
    bit expRead;
    bit expAddr;
    expRead = running && (k <= LAST_TS);
    expAddr = running && (k > LAST_ID) && (k <= LAST_TS);
    checkOutput("sid_read",    32'(sid_read),    32'(expRead));
    checkOutput("sid_address", 32'(sid_address), 32'(expAddr));
    checkOutput("busy",        32'(busy),        32'(running));
    checkOutput("done",        32'(done),        32'(expDone));
    checkOutput("id_match",    32'(id_match),    32'(expIdMatch));
    checkOutput("ts_match",    32'(ts_match),    32'(expTsMatch));
    checkOutput("id_value",    id_value,         expId);
    checkOutput("ts_value",    ts_value,         expTs);
  endtask

  // Drives one clock cycle: slave data and start go out before the rising
  // edge, and the outputs are checked on the following falling edge.
  task automatic applyStimulus(input bit st);
    start = st;
    if (running && k == LAST_ID)      sid_readdata = word0;
    else if (running && k == LAST_TS) sid_readdata = word1;
    else                              sid_readdata = $urandom();
    @(posedge clock);
    modelEdge(st);
    @(negedge clock);
    checkAll();
    start = 1'b0;
  endtask

  // Asserts reset with no clock edge in between and checks the cleared
  // outputs right away. Release happens on a falling edge, so the next
  // rising edge is the auto-start edge.
  task automatic doReset(input int cycles);
    reset_n = 1'b0;
    #1;
    modelReset();
    checkAll();
    repeat (cycles) @(negedge clock);
    reset_n = 1'b1;
  endtask

  initial begin
    word0 = EXP_ID;
    word1 = EXP_TS;
    modelReset();
    #2;
    doReset(2);

    $display("[TB] auto-start check with matching slave words");
    repeat (CMP_K + 3) applyStimulus(1'b0);

    $display("[TB] timestamp off by one");
    word1 = EXP_TS + 32'd1;
    applyStimulus(1'b1);
    repeat (CMP_K + 2) applyStimulus(1'b0);

    $display("[TB] start pulses while busy are ignored");
    word1 = EXP_TS;
    applyStimulus(1'b1);
    applyStimulus(1'b1);
    applyStimulus(1'b1);
    repeat (CMP_K + 2) applyStimulus(1'b0);

    $display("[TB] word 0 changed to 5, rerun from DONE");
    word0 = 32'd5;
    applyStimulus(1'b1);
    repeat (CMP_K + 2) applyStimulus(1'b0);

    $display("[TB] reset during the timestamp read");
    word0 = EXP_ID;
    applyStimulus(1'b1);
    repeat (LAST_ID + 1) applyStimulus(1'b0);
    doReset(1);
    repeat (CMP_K + 3) applyStimulus(1'b0);

    $display("[TB] randomized starts, slave words and resets");
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0)
        word0 = ($urandom_range(0, 1) == 0) ? EXP_ID : $urandom();
      if ($urandom_range(0, 3) == 0)
        word1 = ($urandom_range(0, 1) == 0) ? EXP_TS : $urandom();
      if ($urandom_range(0, 149) == 0)
        doReset(int'($urandom_range(1, 3)));
      else
        applyStimulus($urandom_range(0, 3) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
